icache_fetch_responder: RTL and testbench

- Memory-side responder for the core's instruction-fetch interface (addr/addr_valid/addr_ready request channel, 64-bit data/data_valid response channel).
- Holds a 64-bit-wide instruction store; each word is one fetch packet of two RV32 instructions, low instruction in [31:0].
- Accepts one fetch at a time and returns the packet after a programmable latency.
- Used as the simulation/FPGA instruction memory model for Ladder; has a program-load port for bench/boot loading.

---
 rtl/ladder_mem_pkg.sv | 44 ++++
 rtl/fetch_store_ram.sv | 54 +++++
 rtl/icache_fetch_responder.sv | 191 +++++++++++++++++++
 tb/tb_icache_fetch_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ladder_mem_pkg.sv
// ----------------------------------------------------------------------------
// ladder_mem_pkg
// Definitions shared by the Ladder instruction-memory model: fetch packet
// width, the default error packet, responder FSM states, error-cause codes
// and the error classification helper.
// ----------------------------------------------------------------------------
package ladder_mem_pkg;

   localparam int unsigned PKT_W = 64;

   // Two RV32 "addi x0,x0,0" instructions.
   localparam logic [63:0] NOP_PACKET_C = 64'h0000_0013_0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_RANGE    = 2'd2,
      ERR_WRITE    = 2'd3
   } fetch_err_e;

   // A write attempt is reported ahead of address problems.
   function automatic fetch_err_e classify_fetch(input logic misalign,
                                                 input logic out_of_range,
                                                 input logic wen);
      fetch_err_e cause;
      if (wen) begin
         cause = ERR_WRITE;
      end else if (misalign) begin
         cause = ERR_MISALIGN;
      end else if (out_of_range) begin
         cause = ERR_RANGE;
      end else begin
         cause = ERR_NONE;
      end
      return cause;
   endfunction

endpackage

// File: rtl/fetch_store_ram.sv
// ----------------------------------------------------------------------------
// fetch_store_ram
// DEPTH x 64-bit synchronous instruction store. One write port (program
// load) and one registered read port. A read and a write of the same index
// on the same edge return the old contents.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   async active-low reset (read register only; contents not reset)
//   we_i     write strobe
//   widx_i   write index
//   wdata_i  write data
//   re_i     read enable; read register holds when low
//   ridx_i   read index
//   rdata_o  registered read data
// ----------------------------------------------------------------------------
module fetch_store_ram
   import ladder_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [IDX_W-1:0] widx_i,
   input  logic [PKT_W-1:0] wdata_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] ridx_i,
   output logic [PKT_W-1:0] rdata_o
);

   logic [PKT_W-1:0] mem_q [DEPTH];
   logic [PKT_W-1:0] rdata_q;

   // Program-load write port.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[widx_i] <= wdata_i;
      end
   end

   // Read register; non-blocking update yields pre-write data on collision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= {PKT_W{1'b0}};
      end else if (re_i) begin
         rdata_q <= mem_q[ridx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_fetch_responder.sv
// ----------------------------------------------------------------------------
// icache_fetch_responder
// Memory-side responder for the core instruction-fetch interface. Accepts
// one fetch at a time and returns a 64-bit packet (two RV32 instructions,
// low instruction in [31:0]) LATENCY cycles after the accept. Misaligned,
// out-of-range and write requests return NOP_PACKET with o_err.
//
// Optional build macro: ICACHE_FETCH_RESP_RANDSTALL_EN adds an LFSR that
// inserts 0..3 extra latency cycles per fetch and randomly drops ready in IDLE.
//
// Ports:
//   clock, resetn            clock / async active-low reset
//   i_addr, i_addr_valid     fetch request (byte address)
//   i_wen                    write request flag (always rejected)
//   o_addr_ready             request can be accepted this cycle
//   o_data, o_data_valid     response packet and one-cycle strobe
//   o_err                    one-cycle error strobe with o_data_valid
//   prog_we/prog_idx/prog_data  program-load port into the store
//   o_fetch_cnt              accepted-request counter (wraps)
// ----------------------------------------------------------------------------
module icache_fetch_responder
   import ladder_mem_pkg::*;
#(
   parameter int          ADDR_W     = 32,
   parameter int          DEPTH      = 1024,
   parameter int          LATENCY    = 2,
   parameter logic [63:0] NOP_PACKET = NOP_PACKET_C
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [ADDR_W-1:0]        i_addr,
   input  logic                     i_addr_valid,
   input  logic                     i_wen,
   output logic                     o_addr_ready,
   output logic [63:0]              o_data,
   output logic                     o_data_valid,
   output logic                     o_err,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_idx,
   input  logic [63:0]              prog_data,
   output logic [31:0]              o_fetch_cnt
);

   localparam int         IDX_W = $clog2(DEPTH);
   localparam logic [4:0] LAT_C = 5'(LATENCY);

   fetch_state_e     state_q, state_d;
   logic [4:0]       wait_q, wait_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   fetch_err_e       cause_q, cause_d;
   logic             ready_q, ready_d;
   logic             dv_q, dv_d;
   logic             err_q, err_d;
   logic             resp_err_q, resp_err_d;
   logic [31:0]      fcnt_q, fcnt_d;
   logic             accept_s;
   logic             rd_en_s;
   logic [4:0]       lat_s;
   logic             stall_s;
   logic [63:0]      ram_rdata_s;
   logic             unused_addr_s;

   // Bit 2 selects the packet half; the core does that selection itself.
   assign unused_addr_s = i_addr[2];
   assign accept_s      = i_addr_valid & ready_q;

`ifdef ICACHE_FETCH_RESP_RANDSTALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
   assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign lat_s   = LAT_C + {3'b000, lfsr_q[1:0]};
   // Evaluated on the next value so ready_q lines up with the LFSR it came from.
   assign stall_s = (lfsr_d[4:2] == 3'b000);

   // LFSR state register, free-running.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign lat_s   = LAT_C;
   assign stall_s = 1'b0;
`endif

   // FSM state and latency counter register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         wait_q  <= 5'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic; RESP with a new accept behaves exactly like IDLE.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE, RESP: begin
            if (accept_s) begin
               wait_d  = lat_s - 5'd1;
               state_d = (lat_s == 5'd1) ? RESP : WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            wait_d = wait_q - 5'd1;
            if (wait_q == 5'd1) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
            wait_d  = 5'd0;
         end
      endcase
   end

   // Output / capture next values. The store read happens at the edge that
   // raises o_data_valid, i.e. while state_q is RESP.
   always_comb begin
      ready_d    = (state_d != WAIT) && !((state_d == IDLE) && stall_s);
      dv_d       = (state_q == RESP);
      err_d      = dv_d && (cause_q != ERR_NONE);
      resp_err_d = dv_d ? (cause_q != ERR_NONE) : resp_err_q;
      fcnt_d     = accept_s ? (fcnt_q + 32'd1) : fcnt_q;
      if (accept_s) begin
         idx_d   = i_addr[IDX_W+2:3];
         cause_d = classify_fetch(i_addr[1:0] != 2'b00,
                                  |i_addr[ADDR_W-1:IDX_W+3],
                                  i_wen);
      end else begin
         idx_d   = idx_q;
         cause_d = cause_q;
      end
   end

   assign rd_en_s = dv_d && (cause_q == ERR_NONE);

   // Registered outputs and captured request.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ready_q    <= 1'b0;
         dv_q       <= 1'b0;
         err_q      <= 1'b0;
         resp_err_q <= 1'b0;
         fcnt_q     <= 32'd0;
         idx_q      <= {IDX_W{1'b0}};
         cause_q    <= ERR_NONE;
      end else begin
         ready_q    <= ready_d;
         dv_q       <= dv_d;
         err_q      <= err_d;
         resp_err_q <= resp_err_d;
         fcnt_q     <= fcnt_d;
         idx_q      <= idx_d;
         cause_q    <= cause_d;
      end
   end

   fetch_store_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_store (
      .clk_i   (clock),
      .rst_ni  (resetn),
      .we_i    (prog_we),
      .widx_i  (prog_idx),
      .wdata_i (prog_data),
      .re_i    (rd_en_s),
      .ridx_i  (idx_q),
      .rdata_o (ram_rdata_s)
   );

   // Both mux inputs are registers, so the held packet stays stable.
   assign o_data       = resp_err_q ? NOP_PACKET : ram_rdata_s;
   assign o_addr_ready = ready_q;
   assign o_data_valid = dv_q;
   assign o_err        = err_q;
   assign o_fetch_cnt  = fcnt_q;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// ----------------------------------------------------------------------------
// tb_icache_fetch_responder
// Directed bench. Three responders share the clock and program-load port:
// index 0 with LATENCY=2, index 1 with LATENCY=1, index 2 with LATENCY=4.
// ----------------------------------------------------------------------------
module tb_icache_fetch_responder;

   localparam logic [63:0] P0   = 64'h0050_8113_0050_8093;
   localparam logic [63:0] P1   = 64'h1111_2222_3333_4444;
   localparam logic [63:0] P2   = 64'h5555_6666_7777_8888;
   localparam logic [63:0] P3   = 64'h3333_3333_CCCC_CCCC;
   localparam logic [63:0] PA   = 64'h0000_0000_0000_AAAA;
   localparam logic [63:0] NOPP = 64'h0000_0013_0000_0013;

   logic        clock;
   logic        resetn   [3];
   logic [31:0] addr     [3];
   logic        avalid   [3];
   logic        wen      [3];
   logic        ready    [3];
   logic [63:0] data     [3];
   logic        dv       [3];
   logic        err      [3];
   logic [31:0] fcnt     [3];
   logic        prog_we;
   logic [9:0]  prog_idx;
   logic [63:0] prog_data;

   int n_chk  = 0;
   int n_pass = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      icache_fetch_responder #(
         .ADDR_W  (32),
         .DEPTH   (1024),
         .LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
      ) dut (
         .clock        (clock),
         .resetn       (resetn[g]),
         .i_addr       (addr[g]),
         .i_addr_valid (avalid[g]),
         .i_wen        (wen[g]),
         .o_addr_ready (ready[g]),
         .o_data       (data[g]),
         .o_data_valid (dv[g]),
         .o_err        (err[g]),
         .prog_we      (prog_we),
         .prog_idx     (prog_idx),
         .prog_data    (prog_data),
         .o_fetch_cnt  (fcnt[g])
      );
   end

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic prog(input logic [9:0] idx, input logic [63:0] d);
      prog_we   = 1'b1;
      prog_idx  = idx;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
   endtask

   // One fetch on responder k, checking the exact response cycle and that
   // valid/err are single-cycle strobes while data is held afterwards.
   task automatic fetch(input int k, input logic [31:0] a, input logic w, input int lat,
                        input logic [63:0] exp_d, input logic exp_e, input string tag);
      addr[k]   = a;
      wen[k]    = w;
      avalid[k] = 1'b1;
      tick();
      avalid[k] = 1'b0;
      wen[k]    = 1'b0;
      for (int i = 0; i < lat; i++) begin
         chk({tag, "_early_dv"}, {63'd0, dv[k]}, 64'd0);
         tick();
      end
      chk({tag, "_dv"},   {63'd0, dv[k]},  64'd1);
      chk({tag, "_data"}, data[k],         exp_d);
      chk({tag, "_err"},  {63'd0, err[k]}, {63'd0, exp_e});
      tick();
      chk({tag, "_dv_drop"},   {63'd0, dv[k]},  64'd0);
      chk({tag, "_err_drop"},  {63'd0, err[k]}, 64'd0);
      chk({tag, "_data_hold"}, data[k],         exp_d);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         resetn[k] = 1'b1;
         addr[k]   = 32'd0;
         avalid[k] = 1'b0;
         wen[k]    = 1'b0;
      end
      prog_we   = 1'b0;
      prog_idx  = 10'd0;
      prog_data = 64'd0;
      #1;
      for (int k = 0; k < 3; k++) resetn[k] = 1'b0;
      #1;
      chk("rst_ready", {63'd0, ready[0]}, 64'd0);
      chk("rst_dv",    {63'd0, dv[0]},    64'd0);
      chk("rst_err",   {63'd0, err[0]},   64'd0);
      chk("rst_data",  data[0],           64'd0);
      chk("rst_cnt",   {32'd0, fcnt[0]},  64'd0);
      tick();
      tick();
      for (int k = 0; k < 3; k++) resetn[k] = 1'b1;
      chk("rel_ready_before_edge", {63'd0, ready[0]}, 64'd0);
      tick();

      prog(10'd0, P0);
      prog(10'd1, P1);
      prog(10'd2, P2);
      prog(10'd3, P3);
      prog(10'd1023, P1);

`ifdef ICACHE_FETCH_RESP_RANDSTALL_EN
      begin
         logic [63:0] model [4];
         int          idx;
         int          w;
         int          lat;
         model[0] = P0;
         model[1] = P1;
         model[2] = P2;
         model[3] = P3;
         for (int n = 0; n < 200; n++) begin
            idx       = int'($urandom_range(0, 3));
            addr[0]   = 32'(idx) << 3;
            avalid[0] = 1'b1;
            w = 0;
            while (!ready[0] && w < 64) begin
               tick();
               w++;
            end
            chk("rs_ready_bound", {63'd0, ready[0]}, 64'd1);
            tick();
            avalid[0] = 1'b0;
            lat = 0;
            while (!dv[0] && lat < 8) begin
               tick();
               lat++;
            end
            chk("rs_lat_range", {63'd0, (lat >= 2 && lat <= 5)}, 64'd1);
            chk("rs_data", data[0], model[idx]);
            chk("rs_err",  {63'd0, err[0]}, 64'd0);
         end
         chk("rs_cnt", {32'd0, fcnt[0]}, 64'd200);
      end
`else
      chk("rel_ready_l2", {63'd0, ready[0]}, 64'd1);
      chk("rel_ready_l1", {63'd0, ready[1]}, 64'd1);

      // Latency 2, basic fetch.
      fetch(0, 32'h0, 1'b0, 2, P0, 1'b0, "lat2_idx0");
      chk("lat2_cnt1", {32'd0, fcnt[0]}, 64'd1);
      fetch(0, 32'h4,    1'b0, 2, P0,   1'b0, "upper_half");
      fetch(0, 32'h1FF8, 1'b0, 2, P1,   1'b0, "last_idx");
      fetch(0, 32'h2,    1'b0, 2, NOPP, 1'b1, "misalign");
      fetch(0, 32'h2000, 1'b0, 2, NOPP, 1'b1, "out_of_range");
      fetch(0, 32'h0,    1'b1, 2, NOPP, 1'b1, "write_req");
      fetch(0, 32'h0,    1'b0, 2, P0,   1'b0, "after_write");
      chk("lat2_cnt7", {32'd0, fcnt[0]}, 64'd7);

      // Collision: program idx3 on the edge that reads idx3.
      addr[0]   = 32'h18;
      avalid[0] = 1'b1;
      tick();
      avalid[0] = 1'b0;
      chk("coll_dv_t1", {63'd0, dv[0]}, 64'd0);
      tick();
      prog_we   = 1'b1;
      prog_idx  = 10'd3;
      prog_data = PA;
      chk("coll_dv_t2", {63'd0, dv[0]}, 64'd0);
      tick();
      prog_we   = 1'b0;
      chk("coll_dv",   {63'd0, dv[0]}, 64'd1);
      chk("coll_data", data[0], P3);
      tick();
      fetch(0, 32'h18, 1'b0, 2, PA, 1'b0, "coll_after");

      // Back-to-back on the LATENCY=1 responder.
      addr[1]   = 32'h0;
      avalid[1] = 1'b1;
      tick();
      chk("b2b_ready_a", {63'd0, ready[1]}, 64'd1);
      chk("b2b_dv_a",    {63'd0, dv[1]},    64'd0);
      addr[1] = 32'h8;
      tick();
      chk("b2b_dv0",    {63'd0, dv[1]},    64'd1);
      chk("b2b_data0",  data[1],           P0);
      chk("b2b_ready0", {63'd0, ready[1]}, 64'd1);
      addr[1] = 32'h10;
      tick();
      avalid[1] = 1'b0;
      chk("b2b_dv1",    {63'd0, dv[1]},    64'd1);
      chk("b2b_data1",  data[1],           P1);
      chk("b2b_ready1", {63'd0, ready[1]}, 64'd1);
      tick();
      chk("b2b_dv2",    {63'd0, dv[1]},    64'd1);
      chk("b2b_data2",  data[1],           P2);
      chk("b2b_ready2", {63'd0, ready[1]}, 64'd1);
      tick();
      chk("b2b_dv_end", {63'd0, dv[1]},    64'd0);
      chk("b2b_cnt",    {32'd0, fcnt[1]},  64'd3);

      // Reset two cycles into a LATENCY=4 fetch.
      addr[2]   = 32'h8;
      avalid[2] = 1'b1;
      tick();
      avalid[2] = 1'b0;
      chk("mid_cnt1", {32'd0, fcnt[2]}, 64'd1);
      tick();
      tick();
      resetn[2] = 1'b0;
      #1;
      chk("mid_rst_ready", {63'd0, ready[2]}, 64'd0);
      chk("mid_rst_dv",    {63'd0, dv[2]},    64'd0);
      chk("mid_rst_err",   {63'd0, err[2]},   64'd0);
      chk("mid_rst_data",  data[2],           64'd0);
      chk("mid_rst_cnt",   {32'd0, fcnt[2]},  64'd0);
      tick();
      resetn[2] = 1'b1;
      chk("mid_rel_ready_before", {63'd0, ready[2]}, 64'd0);
      tick();
      chk("mid_rel_ready", {63'd0, ready[2]}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("mid_no_dv", {63'd0, dv[2]}, 64'd0);
         tick();
      end
      fetch(2, 32'h8, 1'b0, 4, P1, 1'b0, "lat4_after_rst");
      chk("lat4_cnt", {32'd0, fcnt[2]}, 64'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
